// File: rtl/itof_pipe.sv
// itof_pipe: three-stage pipelined integer-to-binary32 converter.
//
// The operand is split into sign and magnitude, normalised so that its
// leading one sits at the top, then rounded and packed. Results use either
// round-to-nearest-even or round-toward-zero, chosen per operation. A tag
// travels with each operation. A single global stall freezes every stage
// while a result waits at the output.
//
// Ports
//   clk, rst          clock; synchronous active-high reset
//   in_valid/in_ready input handshake (in_ready = !stall)
//   in_x              IN_WIDTH-bit integer operand
//   in_signed         1: in_x is two's complement, 0: unsigned
//   in_rtz            1: round toward zero, 0: round to nearest even
//   in_tag            opaque tag returned with the result
//   out_valid/out_ready output handshake
//   out_y             binary32 result
//   out_tag           tag belonging to out_y
//   out_inexact       result differs from the exact integer value
module itof_pipe #(
    parameter int IN_WIDTH  = 32,
    parameter int TAG_WIDTH = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IN_WIDTH-1:0]  in_x,
    input  logic                 in_signed,
    input  logic                 in_rtz,
    input  logic [TAG_WIDTH-1:0] in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_y,
    output logic [TAG_WIDTH-1:0] out_tag,
    output logic                 out_inexact
);

    // Leading-one index width: enough for positions up to 63.
    localparam int PW = 7;
    // The rounding window needs the hidden bit, 23 fraction bits, guard and
    // at least one sticky bit, so narrow operands are zero-padded to 26 bits.
    localparam int EW = (IN_WIDTH < 26) ? 26 : IN_WIDTH;

    logic stall;

    logic                 vld_p1, sign_p1, rtz_p1;
    logic [IN_WIDTH-1:0]  mag_p1;
    logic [TAG_WIDTH-1:0] tag_p1;

    logic                 vld_p2, sign_p2, rtz_p2;
    logic [PW-1:0]        lead_p2;
    logic [IN_WIDTH-1:0]  norm_p2;
    logic [TAG_WIDTH-1:0] tag_p2;

    logic                 vld_p3, inexact_p3;
    logic [31:0]          y_p3;
    logic [TAG_WIDTH-1:0] tag_p3;

    logic [PW-1:0]        lead_d;
    logic [IN_WIDTH-1:0]  norm_d;

    // Two's complement magnitude; the most negative value maps to
    // 2^(IN_WIDTH-1), which still fits as an unsigned IN_WIDTH-bit number.
    function automatic logic [IN_WIDTH-1:0] magnitude(input logic signed [IN_WIDTH-1:0] x,
                                                      input logic neg);
        return neg ? IN_WIDTH'(-x) : IN_WIDTH'(x);
    endfunction

    // Round and pack a normalised magnitude. Returns {inexact, binary32}.
    // A normalised operand with a clear top bit can only be zero, so the top
    // bit doubles as the zero flag.
    function automatic logic [32:0] round_pack(input logic          sign,
                                               input logic          rtz,
                                               input logic [PW-1:0] lead,
                                               input logic [IN_WIDTH-1:0] norm);
        logic [EW-1:0] ext;
        logic [22:0]   frac;
        logic          guard, sticky, inc;
        logic [23:0]   sum;
        logic [7:0]    exp;
        ext    = EW'(norm) << (EW - IN_WIDTH);
        frac   = ext[EW-2 -: 23];
        guard  = ext[EW-25];
        sticky = |ext[EW-26:0];
        inc    = !rtz && guard && (sticky || frac[0]);
        sum    = {1'b0, frac} + {23'b0, inc};
        exp    = 8'd127 + {1'b0, lead};
        // Carry out of the fraction: mantissa becomes 1.0, exponent bumps.
        if (sum[23])
            exp = exp + 8'd1;
        if (!ext[EW-1])
            return 33'b0;
        return {guard | sticky, sign, exp, sum[22:0]};
    endfunction

    assign stall     = vld_p3 && !out_ready;
    assign in_ready  = !stall;
    assign out_valid = vld_p3;
    assign out_y     = y_p3;
    assign out_tag   = tag_p3;
    assign out_inexact = inexact_p3;

    always_comb begin
        lead_d = '0;
        for (int i = 0; i < IN_WIDTH; i++)
            if (mag_p1[i])
                lead_d = PW'(i);
        norm_d = mag_p1 << (PW'(IN_WIDTH - 1) - lead_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
            vld_p3 <= 1'b0;
        end else if (!stall) begin
            vld_p1 <= in_valid;
            vld_p2 <= vld_p1;
            vld_p3 <= vld_p2;
        end
    end

    always_ff @(posedge clk) begin
        if (!stall) begin
            // ---- stage p1: sign / magnitude ----
            sign_p1 <= in_signed & in_x[IN_WIDTH-1];
            mag_p1  <= magnitude(in_x, in_signed & in_x[IN_WIDTH-1]);
            rtz_p1  <= in_rtz;
            tag_p1  <= in_tag;
            // ---- stage p2: normalise ----
            sign_p2 <= sign_p1;
            rtz_p2  <= rtz_p1;
            lead_p2 <= lead_d;
            norm_p2 <= norm_d;
            tag_p2  <= tag_p1;
        end
    end

    // ---- stage p3: round / pack ----
    always_ff @(posedge clk) begin
        if (rst) begin
            y_p3       <= '0;
            tag_p3     <= '0;
            inexact_p3 <= 1'b0;
        end else if (!stall) begin
            {inexact_p3, y_p3} <= round_pack(sign_p2, rtz_p2, lead_p2, norm_p2);
            tag_p3             <= tag_p2;
        end
    end

endmodule

// File: tb/tb_itof_pipe.sv
module tb_itof_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, in_valid, in_ready, in_signed, in_rtz;
    logic [31:0] in_x;
    logic [4:0]  in_tag;
    logic        out_valid, out_ready, out_inexact;
    logic [31:0] out_y;
    logic [4:0]  out_tag;

    logic        v64, r64, s64, z64, ov64, or64, ix64;
    logic [63:0] x64;
    logic [4:0]  t64, tg64;
    logic [31:0] y64;

    itof_pipe #(.IN_WIDTH(32), .TAG_WIDTH(5)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_x(in_x), .in_signed(in_signed), .in_rtz(in_rtz), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y),
        .out_tag(out_tag), .out_inexact(out_inexact));

    itof_pipe #(.IN_WIDTH(64), .TAG_WIDTH(5)) dut64 (
        .clk(clk), .rst(rst), .in_valid(v64), .in_ready(r64),
        .in_x(x64), .in_signed(s64), .in_rtz(z64), .in_tag(t64),
        .out_valid(ov64), .out_ready(or64), .out_y(y64),
        .out_tag(tg64), .out_inexact(ix64));

    int checks = 0, failures = 0, cyc = 0, popped = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [4:0]  tag;
        logic [31:0] y;
        logic        inx;
        int          issue;
    } exp_t;
    exp_t q[$];

    typedef struct {
        logic [31:0] x;
        bit          sgn;
        bit          rtz;
        logic [31:0] y;
        bit          inx;
    } vec_t;
    vec_t tbl[11];

    logic [31:0] nxt_y;
    logic        nxt_inx;
    bit          lat_chk, hold_pend;
    logic [37:0] held;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Reference conversion from plain arithmetic: returns {inexact, binary32}.
    function automatic logic [32:0] ref_cvt(input logic [63:0] x, input int w,
                                            input bit sgn, input bit rtz);
        logic [64:0] m, qv, rem, half;
        bit s, inx;
        int p, sh;
        s = sgn && x[w-1];
        m = s ? ((65'd1 << w) - {1'b0, x}) : {1'b0, x};
        if (m == 0) return 33'b0;
        p = 0;
        while ((m >> (p + 1)) != 0) p++;
        inx = 0;
        if (p <= 23) begin
            qv = m << (23 - p);
        end else begin
            sh   = p - 23;
            qv   = m >> sh;
            rem  = m - (qv << sh);
            half = 65'd1 << (sh - 1);
            inx  = (rem != 0);
            if (!rtz && (rem > half || (rem == half && qv[0]))) qv = qv + 1;
            if (qv == (65'd1 << 24)) begin
                qv = qv >> 1;
                p++;
            end
        end
        return {inx, s, 8'(p + 127), qv[22:0]};
    endfunction

    // Called at edge+1 with inputs already driven; samples at edge+2 and
    // returns at the next edge+1.
    task automatic step(output bit acc);
        exp_t e;
        #1;
        chk("in_ready", in_ready, !(out_valid && !out_ready));
        if (hold_pend)
            chk("hold_stable", {out_valid, out_tag, out_inexact, out_y}, {1'b1, held});
        hold_pend = out_valid && !out_ready;
        held = {out_tag, out_inexact, out_y};
        if (q.size() == 0) begin
            chk("spurious_out", out_valid, 0);
        end else if (out_valid && out_ready) begin
            e = q.pop_front();
            chk("result", {out_tag, out_inexact, out_y}, {e.tag, e.inx, e.y});
            if (lat_chk) chk("latency", cyc - e.issue, 3);
            popped++;
        end
        acc = in_valid && in_ready && !rst;
        if (acc) q.push_back('{tag: in_tag, y: nxt_y, inx: nxt_inx, issue: cyc});
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        bit a;
        in_valid  = 0;
        out_ready = 1;
        for (int i = 0; i < 20 && q.size() > 0; i++) step(a);
        chk("drain_timeout", q.size(), 0);
    endtask

    task automatic set_rand32(input logic [4:0] tag);
        logic [31:0] x;
        logic [32:0] r;
        int k;
        case ($urandom_range(0, 3))
            0: x = $urandom;
            1: x = 32'($urandom_range(0, 300));
            2: begin
                k = $urandom_range(25, 31);
                x = (32'd1 << k) + (32'($urandom_range(0, 15)) << (k - 25));
            end
            default: begin
                x = $urandom_range(0, 1) ? 32'hFFFF_FFFF : 32'h8000_0000;
                x = x >> $urandom_range(0, 3);
            end
        endcase
        in_x      = x;
        in_signed = 1'($urandom_range(0, 1));
        in_rtz    = 1'($urandom_range(0, 1));
        in_tag    = tag;
        r = ref_cvt({32'b0, x}, 32, in_signed, in_rtz);
        {nxt_inx, nxt_y} = r;
    endtask

    task automatic run64(input string nm, input logic [63:0] x, input bit sgn, input bit rtz,
                         input logic [31:0] ey, input logic einx);
        int n;
        logic [4:0] t;
        t = 5'($urandom);
        v64 = 1; x64 = x; s64 = sgn; z64 = rtz; t64 = t; or64 = 1;
        #1;
        chk({nm, "_rdy"}, r64, 1);
        @(posedge clk);
        #1;
        v64 = 0;
        n = 1;
        while (!ov64 && n < 8) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({nm, "_lat"}, n, 3);
        chk(nm, {tg64, ix64, y64}, {t, einx, ey});
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit a;
        int i, c;
        logic [63:0] rx;
        logic [32:0] r;

        tbl[0]  = '{32'd1000,      0, 0, 32'h447A_0000, 0};
        tbl[1]  = '{32'd1,         1, 0, 32'h3F80_0000, 0};
        tbl[2]  = '{32'd0,         1, 0, 32'h0000_0000, 0};
        tbl[3]  = '{32'hFFFF_FFFF, 1, 0, 32'hBF80_0000, 0};
        tbl[4]  = '{32'hFFFF_FFFF, 0, 0, 32'h4F80_0000, 1};
        tbl[5]  = '{32'hFFFF_FFFF, 0, 1, 32'h4F7F_FFFF, 1};
        tbl[6]  = '{32'd16777217,  0, 0, 32'h4B80_0000, 1};
        tbl[7]  = '{32'd16777219,  0, 0, 32'h4B80_0002, 1};
        tbl[8]  = '{32'd16777219,  0, 1, 32'h4B80_0001, 1};
        tbl[9]  = '{32'h8000_0000, 1, 0, 32'hCF00_0000, 0};
        tbl[10] = '{32'h8000_0000, 0, 1, 32'h4F00_0000, 0};

        rst = 1; in_valid = 1; in_x = 32'd5; in_signed = 0; in_rtz = 0; in_tag = 5'd9;
        out_ready = 0; v64 = 0; x64 = 0; s64 = 0; z64 = 0; t64 = 0; or64 = 1;
        nxt_y = 0; nxt_inx = 0; lat_chk = 0; hold_pend = 0; held = 0;
        @(posedge clk); @(posedge clk); @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_y", out_y, 0);
        chk("rst_out_tag", out_tag, 0);
        chk("rst_out_inexact", out_inexact, 0);
        chk("rst_out_valid64", ov64, 0);
        rst = 0; in_valid = 0; out_ready = 1;
        #1;
        chk("rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;

        // Table vectors, back-to-back, no stall: latency must be exactly 3.
        lat_chk = 1;
        for (int k = 0; k < 11; k++) begin
            in_valid = 1; in_x = tbl[k].x; in_signed = tbl[k].sgn; in_rtz = tbl[k].rtz;
            in_tag = 5'(k); nxt_y = tbl[k].y; nxt_inx = tbl[k].inx;
            step(a);
        end
        drain();
        lat_chk = 0;

        // Backpressure: 8 ops, out_ready dropped for 4 cycles mid-stream.
        popped = 0; i = 0;
        for (c = 0; c < 40 && i < 8; c++) begin
            out_ready = !(c >= 5 && c < 9);
            in_valid  = 1;
            set_rand32(5'(i));
            step(a);
            if (a) i++;
        end
        drain();
        chk("bp_count", popped, 8);

        // Reset mid-stream: three in flight, dropped by a one-cycle reset.
        out_ready = 1;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1;
            set_rand32(5'(20 + k));
            step(a);
        end
        in_valid = 0; rst = 1;
        step(a);
        rst = 0; q.delete(); hold_pend = 0;
        for (int k = 0; k < 5; k++) step(a);
        lat_chk = 1;
        in_valid = 1;
        set_rand32(5'd30);
        step(a);
        drain();
        lat_chk = 0;

        // Randomised traffic with random backpressure.
        for (int k = 0; k < 300; k++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            set_rand32(5'(k));
            step(a);
        end
        drain();

        // 64-bit build.
        run64("w64_ones_u", 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 32'h5F80_0000, 1);
        run64("w64_min_s",  64'h8000_0000_0000_0000, 1, 0, 32'hDF00_0000, 0);
        for (int k = 0; k < 20; k++) begin
            rx = {$urandom, $urandom} >> $urandom_range(0, 63);
            a  = 1'($urandom_range(0, 1));
            c  = $urandom_range(0, 1);
            r  = ref_cvt(rx, 64, a, c[0]);
            run64("w64_rand", rx, a, c[0], r[31:0], r[32]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
